// File: rtl/fm_nco.sv
// Phase-accumulator NCO driven by the FM controller's swept increment; retunes only at a wrap.
// Optional FM_NCO_PHASE_SYNC_EN: rising edge of update zeroes the phase and loads the increment.
module fm_nco #(
  parameter int DSIZE  = 20,
  parameter int PWIDTH = 24,
  parameter int OWIDTH = 8
) (
  input  logic              inc,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DSIZE-1:0]  incr_in,
  input  logic              update,
  output logic [OWIDTH-1:0] phase_out,
  output logic              sq_out,
  output logic              carry,
  output logic              sweep_start,
  output logic [DSIZE-1:0]  incr_active,
  output logic              pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PWIDTH-1:0]  acc, acc_nxt;
  logic [DSIZE-1:0]   incr_q, incr_pend, incr_pend_nxt, incr_active_nxt;
  logic               update_q, carry_nxt, sync_edge;
  logic [PWIDTH:0]    sum;

  assign sum       = {1'b0, acc} + {{(PWIDTH + 1 - DSIZE){1'b0}}, incr_active};
  assign sync_edge = update & ~update_q;

  assign phase_out = acc[PWIDTH-1 -: OWIDTH];
  assign sq_out    = acc[PWIDTH-1];
  assign pending   = (state == PEND);

  always_comb begin
    state_nxt       = state;
    acc_nxt         = acc;
    incr_active_nxt = incr_active;
    incr_pend_nxt   = incr_pend;
    carry_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          incr_active_nxt = incr_q;
          state_nxt       = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
        end else begin
          acc_nxt   = sum[PWIDTH-1:0];
          carry_nxt = sum[PWIDTH];
          if (incr_q != incr_active) begin
            // A zero increment never wraps, so it must be replaced right away.
            if (incr_active == '0) begin
              incr_active_nxt = incr_q;
            end else begin
              incr_pend_nxt = incr_q;
              state_nxt     = PEND;
            end
          end
        end
      end
      PEND: begin
        if (!en) begin
          incr_pend_nxt = '0;
          state_nxt     = IDLE;
        end else begin
          acc_nxt   = sum[PWIDTH-1:0];
          carry_nxt = sum[PWIDTH];
          if (sum[PWIDTH]) begin
            incr_active_nxt = incr_pend;
            state_nxt       = RUN;
          end else if (incr_q == incr_active) begin
            state_nxt = RUN;
          end else begin
            incr_pend_nxt = incr_q;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef FM_NCO_PHASE_SYNC_EN
    // Sweep start realigns phase to zero so every sweep begins coherently.
    if (sync_edge) begin
      acc_nxt         = '0;
      incr_active_nxt = incr_q;
      incr_pend_nxt   = '0;
      carry_nxt       = 1'b0;
      state_nxt       = en ? RUN : IDLE;
    end
`endif
  end

  always_ff @(posedge inc or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      incr_q      <= '0;
      incr_pend   <= '0;
      incr_active <= '0;
      update_q    <= 1'b0;
      carry       <= 1'b0;
      sweep_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      incr_q      <= incr_in;
      incr_pend   <= incr_pend_nxt;
      incr_active <= incr_active_nxt;
      update_q    <= update;
      carry       <= carry_nxt;
      sweep_start <= sync_edge;
    end
  end

endmodule

// File: tb/tb_fm_nco.sv
// Self-checking bench for fm_nco: directed scenarios plus random traffic against a behavioural model.
module tb_fm_nco;
  localparam int     DW      = 20;
  localparam int     PW      = 24;
  localparam int     OW      = 8;
  localparam int     VW      = OW + 4 + DW;
  localparam longint ACC_MOD = 64'd1 << PW;

  // clock / reset
  logic          inc = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          update = 1'b0;
  logic [DW-1:0] incr_in = '0;
  always #5 inc = ~inc;

  logic [OW-1:0] phase_out;
  logic          sq_out, carry, sweep_start, pending;
  logic [DW-1:0] incr_active;
  logic [VW-1:0] obs;

  fm_nco #(.DSIZE(DW), .PWIDTH(PW), .OWIDTH(OW)) dut (
    .inc         (inc),
    .rst_n       (rst_n),
    .en          (en),
    .incr_in     (incr_in),
    .update      (update),
    .phase_out   (phase_out),
    .sq_out      (sq_out),
    .carry       (carry),
    .sweep_start (sweep_start),
    .incr_active (incr_active),
    .pending     (pending)
  );

  assign obs = {phase_out, sq_out, carry, sweep_start, pending, incr_active};

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // behavioural reference: exp_q models the one-cycle input register
  logic [DW-1:0] exp_q[$];
  logic [PW-1:0] m_acc;
  logic [DW-1:0] m_active, m_pend_val;
  logic          m_run, m_pend, m_carry, m_sweep, m_update_q;

  function automatic void model_reset();
    m_acc = '0; m_active = '0; m_pend_val = '0;
    m_run = 1'b0; m_pend = 1'b0; m_carry = 1'b0; m_sweep = 1'b0; m_update_q = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
  endfunction

  function automatic void model_edge();
    logic [DW-1:0] q_old;
    longint        s;
    logic          ovf, rise;
    q_old = exp_q.pop_front();
    exp_q.push_back(incr_in);
    rise    = update && !m_update_q;
    s       = longint'(m_acc) + longint'(m_active);
    ovf     = (s >= ACC_MOD);
    m_carry = 1'b0;
    if (!m_run) begin
      if (en) begin m_active = q_old; m_run = 1'b1; end
    end else if (!en) begin
      m_run = 1'b0; m_pend = 1'b0;
    end else begin
      m_acc   = PW'(s % ACC_MOD);
      m_carry = ovf;
      if (!m_pend) begin
        if (q_old != m_active && m_active == '0) m_active = q_old;
        else if (q_old != m_active) begin m_pend = 1'b1; m_pend_val = q_old; end
      end else begin
        if (ovf) begin m_active = m_pend_val; m_pend = 1'b0; end
        else if (q_old == m_active) m_pend = 1'b0;
        else m_pend_val = q_old;
      end
    end
`ifdef FM_NCO_PHASE_SYNC_EN
    if (rise) begin
      m_acc = '0; m_active = q_old; m_run = en; m_pend = 1'b0; m_carry = 1'b0;
    end
`endif
    m_sweep    = rise;
    m_update_q = update;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_acc[PW-1 -: OW], m_acc[PW-1], m_carry, m_sweep, m_pend, m_active};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge inc);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic hard_reset();
    @(negedge inc);
    rst_n = 1'b0; en = 1'b0; update = 1'b0; incr_in = '0;
    model_reset();
    @(negedge inc);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    en = 1'b1; incr_in = 20'h12345;
    n_cmp++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", obs); end
    @(posedge inc); #1;
    n_cmp++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_edge: got %h want 0", obs); end
    en = 1'b0; incr_in = '0;
    @(negedge inc);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_idle cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
    end
  endtask

  task automatic test_steady();
    int last_c, n_c, highs;
    logic [OW-1:0] prev_ph;
    last_c = -1; n_c = 0; highs = 0;
    en = 1'b1; incr_in = 20'h80000;
    for (int i = 0; i < 140; i++) begin
      prev_ph = phase_out;
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL steady_model cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
      if (i >= 4) begin
        n_cmp++;
        if (phase_out !== prev_ph + 8'd8) begin n_fail++; $display("FAIL steady_phase_step cyc=%0d: got %h want %h", cyc, phase_out, prev_ph + 8'd8); end
      end
      if (i >= 64 && i < 128 && sq_out === 1'b1) highs++;
      if (carry === 1'b1) begin
        n_c++;
        if (last_c >= 0) begin
          n_cmp++;
          if (i - last_c != 32) begin n_fail++; $display("FAIL steady_carry_spacing: got %0d want 32", i - last_c); end
        end
        last_c = i;
      end
    end
    n_cmp++;
    if (n_c != 4) begin n_fail++; $display("FAIL steady_carry_count: got %0d want 4", n_c); end
    n_cmp++;
    if (highs != 32) begin n_fail++; $display("FAIL steady_sq_duty: got %0d want 32", highs); end
  endtask

  task automatic test_retune();
    bit found;
    int cnt;
    for (int i = 0; i < 40; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL retune_model cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
      if (m_acc == 24'h400000) break;
    end
    incr_in = 20'h40000;
    step(); step();
    n_cmp++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL retune_pending_set: got %b want 1", pending); end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL retune_model cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
      if (carry === 1'b1) found = 1'b1;
      else begin
        n_cmp++;
        if (pending !== 1'b1) begin n_fail++; $display("FAIL retune_pending_hold cyc=%0d: got %b want 1", cyc, pending); end
      end
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL retune_wrap_timeout: got none want carry"); end
    n_cmp++;
    if (incr_active !== 20'h40000) begin n_fail++; $display("FAIL retune_load: got %h want 40000", incr_active); end
    n_cmp++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL retune_pending_clear: got %b want 0", pending); end
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      cnt++;
      if (carry === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found || cnt != 64) begin n_fail++; $display("FAIL retune_spacing: got %0d want 64", cnt); end
  endtask

  task automatic test_double_change();
    bit found;
    int cnt;
    incr_in = 20'h80000;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL double_model cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
      if (carry === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found || incr_active !== 20'h80000) begin n_fail++; $display("FAIL double_base_load: got %h want 80000", incr_active); end
    for (int i = 0; i < 4; i++) step();
    incr_in = 20'h40000;
    for (int i = 0; i < 6; i++) step();
    incr_in = 20'h20000;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL double_model cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
      if (carry === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found || incr_active !== 20'h20000) begin n_fail++; $display("FAIL double_last_wins: got %h want 20000", incr_active); end
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 160 && !found; i++) begin
      step();
      cnt++;
      if (cnt == 1) begin
        n_cmp++;
        if (pending !== 1'b0) begin n_fail++; $display("FAIL double_pending_clear: got %b want 0", pending); end
      end
      if (carry === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found || cnt != 128) begin n_fail++; $display("FAIL double_spacing: got %0d want 128", cnt); end
  endtask

  task automatic test_zero_start();
    bit found;
    int cnt;
    hard_reset();
    en = 1'b1; incr_in = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL zero_model cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
    end
    incr_in = 20'h80000;
    step();
    n_cmp++;
    if (incr_active !== '0) begin n_fail++; $display("FAIL zero_load_early: got %h want 0", incr_active); end
    step();
    n_cmp++;
    if (incr_active !== 20'h80000 || pending !== 1'b0) begin
      n_fail++; $display("FAIL zero_load: got %h/%b want 80000/0", incr_active, pending);
    end
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      cnt++;
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL zero_model cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
      if (carry === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found || cnt != 32) begin n_fail++; $display("FAIL zero_first_carry: got %0d want 32", cnt); end
  endtask

  task automatic test_update();
    logic [OW-1:0] prev_ph;
    for (int i = 0; i < 5; i++) step();
    prev_ph = phase_out;
    update = 1'b1;
    step();
    n_cmp++;
    if (sweep_start !== 1'b1) begin n_fail++; $display("FAIL update_pulse: got %b want 1", sweep_start); end
`ifdef FM_NCO_PHASE_SYNC_EN
    n_cmp++;
    if (phase_out !== '0) begin n_fail++; $display("FAIL update_phase_sync: got %h want 0", phase_out); end
`else
    n_cmp++;
    if (phase_out !== prev_ph + 8'd8) begin n_fail++; $display("FAIL update_phase_cont: got %h want %h", phase_out, prev_ph + 8'd8); end
`endif
    step();
    n_cmp++;
    if (sweep_start !== 1'b0) begin n_fail++; $display("FAIL update_pulse_end: got %b want 0", sweep_start); end
    update = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL update_model cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    hard_reset();
    en = 1'b1; incr_in = 20'h2B931;  // 47 * 0x2B931 == 0x7FFFFF
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL rstmid_model cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
      if (m_acc == 24'h7FFFFF - 24'h057262) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL rstmid_setup_timeout: got none want target"); end
    incr_in = 20'h10000;
    step(); step();
    n_cmp++;
    if (pending !== 1'b1 || phase_out !== 8'h7F || sq_out !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_pend_state: got %b/%h/%b want 1/7f/0", pending, phase_out, sq_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0) begin n_fail++; $display("FAIL rstmid_async_clear: got %h want 0", obs); end
    model_reset();
    @(negedge inc);
    rst_n = 1'b1; incr_in = 20'h55555; en = 1'b1;
    step(); step();
    n_cmp++;
    if (incr_active !== 20'h55555 || phase_out !== '0) begin
      n_fail++; $display("FAIL rstmid_restart: got %h/%h want 55555/00", incr_active, phase_out);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL rstmid_model cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0)
        incr_in = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom_range(32'h08000, 32'hFFFFF));
      if ($urandom_range(0, 29) == 0) en = ~en;
      if ($urandom_range(0, 24) == 0) update = ~update;
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_model cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_steady();
    test_retune();
    test_double_change();
    test_zero_start();
    test_update();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/fm_nco.md
Name: fm_nco

Overview:
- Phase-accumulator NCO that consumes the increment word and sweep-start flag produced by the frequency-modulation controller.
- Turns the swept increment stream into phase, square-wave and wrap-carry outputs.
- Runs in the same `inc` clock domain as the controller.
- Increment changes are applied phase-continuously, only at an accumulator wrap, so the synthesized waveform never glitches mid-cycle.

Parameters:
- DSIZE, 20, increment word width (matches the controller's output).
- PWIDTH, 24, phase accumulator width; must be > DSIZE.
- OWIDTH, 8, phase output width (top bits of the accumulator); must be <= PWIDTH.

Ports:
- inc  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  accumulate enable.
- incr_in  input  DSIZE  increment word from the controller.
- update  input  1  controller sweep-start level (high while the sweep index is 0).
- phase_out  output  OWIDTH  acc[PWIDTH-1 -: OWIDTH].
- sq_out  output  1  acc[PWIDTH-1].
- carry  output  1  one-cycle pulse on accumulator overflow.
- sweep_start  output  1  one-cycle pulse on the rising edge of update.
- incr_active  output  DSIZE  increment currently being accumulated.
- pending  output  1  high while a new increment waits for a wrap.

Behaviour:
- Reset (asynchronous, rst_n low): every register and output is 0, including state, acc, incr_q, incr_pend and update_q.
- Input stage: incr_q <= incr_in every cycle, giving 1 cycle of latency. update_q <= update. sweep_start = update & ~update_q, registered.
- Accumulator arithmetic: sum = {1'b0, acc} + zero-extend(incr_active) to PWIDTH+1 bits. acc <= sum[PWIDTH-1:0]. carry <= sum[PWIDTH] when the state is RUN or PEND, else 0. The overflow is modulo 2^PWIDTH with no saturation.
- IDLE state:
  - acc holds and carry is 0.
  - On en=1: incr_active <= incr_q (immediate load), then go to RUN.
- RUN state, checked in priority order:
  - en=0: go to IDLE; acc holds.
  - incr_q != incr_active and incr_active == 0: load incr_q immediately and stay in RUN. This prevents a deadlock at zero frequency, where no wrap would ever occur.
  - incr_q != incr_active: incr_pend <= incr_q, go to PEND.
- PEND state, checked in priority order:
  - en=0: discard the pending value, go to IDLE.
  - This cycle's sum overflows: incr_active <= incr_pend, go to RUN. The new increment is used from the next add.
  - Otherwise: incr_pend <= incr_q (last value wins), stay in PEND.
  - If incr_q returns to equal incr_active while in PEND: go to RUN without loading.
- pending = (state == PEND).
- Simultaneous wrap and change in RUN: carry pulses, and the change goes to PEND. It is not loaded on that wrap; it waits for the next one.
- Reset mid-operation: all state clears immediately. After release the block sits in IDLE until en=1.
- update carries no other meaning unless the optional feature is enabled.

Optional Feature:
- Macro: FM_NCO_PHASE_SYNC_EN.
- When defined, on the cycle sweep_start is generated (rising edge of update):
  - acc <= 0, incr_active <= incr_q, state <= RUN if en, else IDLE;
  - carry <= 0 that cycle;
  - any pending value is dropped.
- This phase-aligns every sweep to 0 for coherent capture.
- When undefined, update only produces sweep_start; acc and state are unaffected.

Test Plan:
- Reset, then en=1, incr_in=0x80000 held: carry pulses every 32 cycles; sq_out is 16 cycles high / 16 low; phase_out steps by 8.
- While running at 0x80000, change incr_in to 0x40000 mid-period: pending=1 until the next carry; incr_active switches on that carry; subsequent carries are spaced 64 cycles.
- Change incr_in twice (0x40000, then 0x20000) within one period: only 0x20000 is loaded at the wrap; pending then deasserts; carry spacing becomes 128 cycles.
- incr_active=0 running, set incr_in=0x80000: loaded without a wrap, 2 cycles after the input changes; first carry 32 cycles later.
- Toggle update 0->1 with FM_NCO_PHASE_SYNC_EN defined: sweep_start pulses 1 cycle; acc reads 0 in the following cycle. With the macro undefined: sweep_start pulses and acc continues uninterrupted.
- Assert rst_n=0 while in PEND with acc=0x7FFFFF: all outputs are 0 asynchronously; after release with en=1, incr_active = incr_in and acc starts counting from 0.
